// File: rtl/wb_i2c_seq_pkg.sv
// Shared definitions for the I2C burst-read sequencer: register map, UCR bit
// positions, Wishbone constants and the sequencer state encoding.
package wb_i2c_seq_pkg;

  localparam logic [31:0] UCR_OFS  = 32'h0000_0000;
  localparam logic [31:0] DATA_OFS = 32'h0000_0004;
  localparam logic [31:0] ADDR_OFS = 32'h0000_0008;

  localparam int UCR_ENA_BIT    = 3;
  localparam int UCR_ACKERR_BIT = 1;
  localparam int UCR_BUSY_BIT   = 0;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam logic [3:0] MAX_LEN    = 4'd8;

  typedef enum logic [3:0] {
    IDLE,
    WR_PTR,
    WR_CMDW,
    WAIT_HI_W,
    WR_CMDR,
    WAIT_LO_W,
    WAIT_HI_R,
    WR_STOP,
    WAIT_LO_R,
    RD_DATA,
    ABORT,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/wb_i2c_seq_if.sv
// Wishbone master bus bundle between the sequencer and the I2C register block.
interface wb_i2c_seq_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_i2c_seq_wb_mst_port.sv
// Single-access Wishbone master: latches one request, holds cyc/stb until ack,
// then pulses done with the captured read data.
module wb_mst_port
  import wb_i2c_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [31:0]  adr,
  input  logic [31:0]  dat,
  output logic         done,
  output logic [31:0]  rdata,
  wb_i2c_seq_if.master wbm
);

  logic        cyc_reg;
  logic        we_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic        done_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      done_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (cyc_reg) begin
        // Drop the cycle on the edge that sees ack so the bus idles next cycle.
        if (wbm.wbm_ack_i) begin
          cyc_reg   <= 1'b0;
          we_reg    <= 1'b0;
          done_reg  <= 1'b1;
          rdata_reg <= wbm.wbm_dat_i;
        end
      end else if (req) begin
        cyc_reg <= 1'b1;
        we_reg  <= we;
        adr_reg <= adr;
        dat_reg <= dat;
      end
    end
  end

  assign wbm.wbm_cyc_o = cyc_reg;
  assign wbm.wbm_stb_o = cyc_reg;
  assign wbm.wbm_we_o  = we_reg;
  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_dat_o = dat_reg;
  assign wbm.wbm_sel_o = WB_SEL_ALL;
  assign done          = done_reg;
  assign rdata         = rdata_reg;

endmodule

// File: rtl/wb_i2c_seq.sv
// I2C burst-read sequencer driving an I2C register block over Wishbone.
// Optional poll watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module wb_i2c_seq
  import wb_i2c_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [6:0]   dev_addr,
  input  logic [7:0]   reg_addr,
  input  logic [3:0]   len,
  output logic         busy_o,
  output logic         done,
  output logic         err,
  input  logic [2:0]   buf_idx,
  output logic [7:0]   buf_data,
  wb_i2c_seq_if.master wbm
);

  seq_state_e  state_reg;
  logic        pend_reg;
  logic        req_reg;
  logic        req_we_reg;
  logic [31:0] req_adr_reg;
  logic [31:0] req_dat_reg;
  logic [6:0]  dev_reg;
  logic [7:0]  ptr_reg;
  logic [3:0]  len_reg;
  logic [3:0]  idx_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;

  logic        mst_done;
  logic [31:0] mst_rdata;

  logic        acc_we;
  logic [31:0] acc_adr;
  logic [31:0] acc_dat;
  logic        is_bus;
  logic        wait_hi;
  logic        poll_match;
  logic        poll_expired;
  seq_state_e  wait_next;

  logic [7:0]  buf_mem [8];

  wb_mst_port u_port (
    .clk   (clk),
    .reset (reset),
    .req   (req_reg),
    .we    (req_we_reg),
    .adr   (req_adr_reg),
    .dat   (req_dat_reg),
    .done  (mst_done),
    .rdata (mst_rdata),
    .wbm   (wbm)
  );

  // The bus access each state performs; issued once per visit or per poll.
  always_comb begin
    acc_we  = 1'b1;
    acc_adr = BASE_ADDR + UCR_OFS;
    acc_dat = '0;
    case (state_reg)
      WR_PTR: begin
        acc_adr = BASE_ADDR + DATA_OFS;
        acc_dat = {24'h0, ptr_reg};
      end
      WR_CMDW: begin
        acc_adr = BASE_ADDR + ADDR_OFS;
        acc_dat = {24'h0, 1'b0, dev_reg};
      end
      WR_CMDR: begin
        acc_adr = BASE_ADDR + ADDR_OFS;
        acc_dat = {24'h0, 1'b1, dev_reg};
      end
      WAIT_HI_W, WAIT_LO_W, WAIT_HI_R, WAIT_LO_R: acc_we = 1'b0;
      RD_DATA: begin
        acc_we  = 1'b0;
        acc_adr = BASE_ADDR + DATA_OFS;
      end
      default: ;
    endcase
  end

  always_comb begin
    is_bus     = (state_reg != IDLE) && (state_reg != FINISH);
    wait_hi    = (state_reg == WAIT_HI_W) || (state_reg == WAIT_HI_R);
    poll_match = (mst_rdata[UCR_BUSY_BIT] == wait_hi);
    case (state_reg)
      WAIT_HI_W: wait_next = WR_CMDR;
      WAIT_LO_W: wait_next = WAIT_HI_R;
      WAIT_HI_R: wait_next = (idx_reg == len_reg - 4'd1) ? WR_STOP : WAIT_LO_R;
      default:   wait_next = RD_DATA;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt_reg;
  logic        is_wait;
  logic        unused_bits;

  assign is_wait      = (state_reg == WAIT_HI_W) || (state_reg == WAIT_LO_W) ||
                        (state_reg == WAIT_HI_R) || (state_reg == WAIT_LO_R);
  assign poll_expired = (poll_cnt_reg == POLL_LIMIT - 16'd1);
  assign unused_bits  = ^mst_rdata[31:8];

  // A matching poll leaves the state, so restarting the count there covers
  // wait-to-wait transitions as well as entry from a write state.
  always_ff @(posedge clk) begin
    if (reset || !is_wait) begin
      poll_cnt_reg <= '0;
    end else if (mst_done) begin
      poll_cnt_reg <= poll_match ? 16'd0 : poll_cnt_reg + 16'd1;
    end
  end
`else
  logic unused_bits;
  assign poll_expired = 1'b0;
  assign unused_bits  = ^{mst_rdata[31:8], POLL_LIMIT};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pend_reg    <= 1'b0;
      req_reg     <= 1'b0;
      req_we_reg  <= 1'b0;
      req_adr_reg <= '0;
      req_dat_reg <= '0;
      dev_reg     <= '0;
      ptr_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      req_reg  <= 1'b0;
      done_reg <= 1'b0;
      if (is_bus && !pend_reg) begin
        req_reg     <= 1'b1;
        req_we_reg  <= acc_we;
        req_adr_reg <= acc_adr;
        req_dat_reg <= acc_dat;
        pend_reg    <= 1'b1;
      end
      if (mst_done) pend_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len == 4'd0 || len > MAX_LEN) begin
              err_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              dev_reg   <= dev_addr;
              ptr_reg   <= reg_addr;
              len_reg   <= len;
              idx_reg   <= '0;
              err_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= WR_PTR;
            end
          end
        end
        WR_PTR:  if (mst_done) state_reg <= WR_CMDW;
        WR_CMDW: if (mst_done) state_reg <= WAIT_HI_W;
        WR_CMDR: if (mst_done) state_reg <= WAIT_LO_W;
        WR_STOP: if (mst_done) state_reg <= WAIT_LO_R;
        WAIT_HI_W, WAIT_LO_W, WAIT_HI_R, WAIT_LO_R: begin
          if (mst_done) begin
            if (mst_rdata[UCR_ACKERR_BIT]) state_reg <= ABORT;
            else if (poll_match)           state_reg <= wait_next;
            else if (poll_expired)         state_reg <= ABORT;
          end
        end
        RD_DATA: begin
          if (mst_done) begin
            idx_reg <= idx_reg + 4'd1;
            if (idx_reg + 4'd1 == len_reg) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= WAIT_HI_R;
            end
          end
        end
        ABORT: begin
          if (mst_done) begin
            err_reg   <= 1'b1;
            state_reg <= FINISH;
            done_reg  <= 1'b1;
          end
        end
        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Buffer keeps its contents across reset and new bursts.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == RD_DATA && mst_done) begin
      buf_mem[idx_reg[2:0]] <= mst_rdata[7:0];
    end
  end

  assign buf_data = buf_mem[buf_idx];
  assign busy_o   = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_wb_i2c_seq.sv
// Scoreboard bench for wb_i2c_seq against a scripted I2C register-block model.
module tb_wb_i2c_seq;
  import wb_i2c_seq_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [15:0] PLIM = 16'd8;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  typedef struct packed {
    logic err;
    logic busy;
  } done_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [3:0] len = '0;
  logic [2:0] buf_idx = '0;
  logic       busy_o, done, err;
  logic [7:0] buf_data;

  logic        s_ack = 1'b0;
  logic [31:0] s_dat = '0;

  int   n_chk = 0;
  int   n_err = 0;
  int   mode = 0;
  int   ucr_reads = 0;
  int   acc_cnt = 0;
  int   wcnt = 0;
  bit   stalled = 1'b0;
  bit   clr = 1'b0;

  acc_t        exp_q[$];
  done_t       done_q[$];
  logic [7:0]  data_q[$];

  wb_i2c_seq_if wbm ();

  assign wbm.wbm_ack_i = s_ack;
  assign wbm.wbm_dat_i = s_dat;

  wb_i2c_seq #(.BASE_ADDR(BASE), .POLL_LIMIT(PLIM)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .len      (len),
    .busy_o   (busy_o),
    .done     (done),
    .err      (err),
    .buf_idx  (buf_idx),
    .buf_data (buf_data),
    .wbm      (wbm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mode 0: busy 0,0,1,1,... ; 1: ack_error; 2: busy stuck 0; 3: busy 1,0,1,0 then stall.
  function automatic logic [31:0] ucr_value(input int n, input int m);
    logic [31:0] v;
    v = 32'h0000_0008;
    case (m)
      0: v[0] = ((n / 2) % 2) == 1;
      1: v[1] = 1'b1;
      3: v[0] = (n % 2) == 0;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    s_ack <= 1'b0;
    if (clr) begin
      ucr_reads = 0;
      stalled   = 1'b0;
      wcnt      = 0;
    end else if (wbm.wbm_cyc_o && wbm.wbm_stb_o && !s_ack) begin
      if (mode == 3 && ucr_reads == 3 && !wbm.wbm_we_o && wbm.wbm_adr_o == BASE + UCR_OFS) begin
        stalled = 1'b1;
      end else if (wcnt < acc_cnt % 3) begin
        wcnt++;
      end else begin
        wcnt = 0;
        acc_cnt++;
        s_ack <= 1'b1;
        if (!wbm.wbm_we_o) begin
          if (wbm.wbm_adr_o == BASE + UCR_OFS) begin
            s_dat <= ucr_value(ucr_reads, mode);
            ucr_reads++;
          end else if (wbm.wbm_adr_o == BASE + DATA_OFS && data_q.size() > 0) begin
            s_dat <= {24'h0, data_q.pop_front()};
          end else begin
            s_dat <= 32'h0000_00EE;
          end
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  logic        prev_cyc = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;

  // Monitor: compares every non-poll access and every done pulse against the queues.
  always @(negedge clk) begin
    acc_t  e;
    done_t d;
    if (!reset) begin
      if (prev_ack) check("bus_idle_after_ack", 64'(wbm.wbm_cyc_o), 64'd0);
      if (wbm.wbm_cyc_o && prev_cyc && !prev_ack)
        check("bus_stable", {31'h0, wbm.wbm_we_o, wbm.wbm_adr_o ^ wbm.wbm_dat_o},
              {31'h0, prev_we, prev_adr ^ prev_dat});
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o && s_ack) begin
        check("sel", 64'(wbm.wbm_sel_o), 64'hF);
        if (wbm.wbm_we_o || wbm.wbm_adr_o != BASE + UCR_OFS) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_access: got we=%0b adr=%0h dat=%0h required none",
                     wbm.wbm_we_o, wbm.wbm_adr_o, wbm.wbm_dat_o);
          end else begin
            e = exp_q.pop_front();
            check("access", {wbm.wbm_we_o ? wbm.wbm_dat_o : 32'h0, wbm.wbm_adr_o ^ {31'h0, wbm.wbm_we_o}},
                  {e.dat, e.adr ^ {31'h0, e.we}});
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          d = done_q.pop_front();
          check("done_err_busy", 64'({err, busy_o}), 64'({d.err, d.busy}));
        end
      end
    end
    prev_cyc = wbm.wbm_cyc_o;
    prev_ack = s_ack;
    prev_we  = wbm.wbm_we_o;
    prev_adr = wbm.wbm_adr_o;
    prev_dat = wbm.wbm_dat_o;
  end

  task automatic push_w(input logic [31:0] ofs, input logic [7:0] v);
    exp_q.push_back('{we: 1'b1, adr: BASE + ofs, dat: {24'h0, v}});
  endtask

  task automatic push_r(input logic [31:0] ofs);
    exp_q.push_back('{we: 1'b0, adr: BASE + ofs, dat: 32'h0});
  endtask

  task automatic set_mode(input int m);
    @(posedge clk); #1;
    clr  = 1'b1;
    mode = m;
    @(posedge clk); #1;
    clr  = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] d, input logic [7:0] r, input logic [3:0] l);
    @(posedge clk); #1;
    dev_addr = d;
    reg_addr = r;
    len      = l;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(n < 4000), 64'd1);
    @(posedge clk); #1;
    check({name, "_busy_after"}, 64'(busy_o), 64'd0);
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_buf(input string name, input logic [2:0] i, input logic [7:0] v);
    buf_idx = i;
    #1;
    check(name, 64'(buf_data), 64'(v));
  endtask

  task automatic burst6(input logic [7:0] base_val);
    for (int i = 0; i < 6; i++) data_q.push_back(base_val + 8'(i));
    push_w(DATA_OFS, 8'h3B);
    push_w(ADDR_OFS, 8'h68);
    push_w(ADDR_OFS, 8'hE8);
    for (int i = 0; i < 5; i++) push_r(DATA_OFS);
    push_w(UCR_OFS, 8'h00);
    push_r(DATA_OFS);
    done_q.push_back('{err: 1'b0, busy: 1'b1});
    do_start(7'h68, 8'h3B, 4'd6);
    check("burst6_busy_running", 64'(busy_o), 64'd1);
    wait_done("burst6");
    for (int i = 0; i < 6; i++) check_buf("burst6_buf", 3'(i), base_val + 8'(i));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cyc_stb_we", 64'({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o}), 64'd0);
    check("rst_adr", 64'(wbm.wbm_adr_o), 64'd0);
    check("rst_dat", 64'(wbm.wbm_dat_o), 64'd0);
    check("rst_sel", 64'(wbm.wbm_sel_o), 64'hF);

    // Six-byte burst from 0x3B of device 0x68.
    set_mode(0);
    burst6(8'h10);
    check("burst6_err", 64'(err), 64'd0);

    // Single byte: stop write must precede the only DATA read.
    set_mode(0);
    data_q.push_back(8'hA5);
    push_w(DATA_OFS, 8'h00);
    push_w(ADDR_OFS, 8'h50);
    push_w(ADDR_OFS, 8'hD0);
    push_w(UCR_OFS, 8'h00);
    push_r(DATA_OFS);
    done_q.push_back('{err: 1'b0, busy: 1'b1});
    do_start(7'h50, 8'h00, 4'd1);
    wait_done("len1");
    check_buf("len1_buf0", 3'd0, 8'hA5);
    check_buf("len1_buf1_kept", 3'd1, 8'h11);

    // len=0: no bus traffic, error and done on the following cycle.
    done_q.push_back('{err: 1'b1, busy: 1'b0});
    do_start(7'h68, 8'h3B, 4'd0);
    check("len0_done_next", 64'(done), 64'd1);
    check("len0_err", 64'(err), 64'd1);
    wait_done("len0");

    // ack_error reported on the first poll.
    set_mode(1);
    push_w(DATA_OFS, 8'h3B);
    push_w(ADDR_OFS, 8'h68);
    push_w(UCR_OFS, 8'h00);
    done_q.push_back('{err: 1'b1, busy: 1'b1});
    do_start(7'h68, 8'h3B, 4'd6);
    check("ackerr_start_clears_err", 64'(err), 64'd0);
    wait_done("ackerr");
    check("ackerr_polls", 64'(ucr_reads), 64'd1);
    check("ackerr_err_sticky", 64'(err), 64'd1);
    check_buf("ackerr_buf0_kept", 3'd0, 8'hA5);

    // Reset while a WAIT_LO_R poll is held without ack.
    set_mode(3);
    push_w(DATA_OFS, 8'h3B);
    push_w(ADDR_OFS, 8'h68);
    push_w(ADDR_OFS, 8'hE8);
    do_start(7'h68, 8'h3B, 4'd6);
    n = 0;
    while (!stalled && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached", 64'(stalled), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cyc_stb", 64'({wbm.wbm_cyc_o, wbm.wbm_stb_o}), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    set_mode(0);
    burst6(8'h20);

    // len=9 is out of range.
    done_q.push_back('{err: 1'b1, busy: 1'b0});
    do_start(7'h68, 8'h3B, 4'd9);
    check("len9_done_next", 64'(done), 64'd1);
    wait_done("len9");
    check("len9_err", 64'(err), 64'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Busy never rises: watchdog aborts after POLL_LIMIT polls.
    set_mode(2);
    push_w(DATA_OFS, 8'h3B);
    push_w(ADDR_OFS, 8'h68);
    push_w(UCR_OFS, 8'h00);
    done_q.push_back('{err: 1'b1, busy: 1'b1});
    do_start(7'h68, 8'h3B, 4'd6);
    wait_done("timeout");
    check("timeout_polls", 64'(ucr_reads), 64'd8);
    check("timeout_err", 64'(err), 64'd1);
`endif

    repeat (4) @(posedge clk);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_i2c_seq.md
WB_I2C_SEQ -- requirements
Module: wb_i2c_seq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, Wishbone base address of the I2C register block.
REQ-002 SHALL have parameter POLL_LIMIT, default 16'd4095, maximum status polls per wait (used only with REQ-027).
REQ-003 SHALL have ports: clk in 1 system clock; reset in 1 reset.
REQ-004 SHALL have ports: start in 1 begin burst read (sampled in IDLE); dev_addr in 7 slave address; reg_addr in 8 first register; len in 4 byte count, 1..8.
REQ-005 SHALL have ports: busy_o out 1 sequence active; done out 1 one-cycle completion pulse; err out 1 sticky error flag.
REQ-006 SHALL have ports: buf_idx in 3 read index; buf_data out 8 combinational read of buffer[buf_idx].
REQ-007 SHALL have Wishbone master ports: wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_adr_o out 32; wbm_sel_o out 4; wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i in 1.
REQ-008 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-009 Register map targeted: UCR at BASE+0x00 (bit3 ena, bit1 ack_error, bit0 busy), DATA at BASE+0x04, ADDR-RW at BASE+0x08 ({rw,addr[6:0]} in bits 7:0).
REQ-010 Bus rule: one access at a time; cyc=stb=1 held with stable adr/we/dat until first cycle wbm_ack_i=1; both deasserted next cycle; sel always 4'hF; at least one idle cycle between accesses.
REQ-011 start with len=0 or len>8 SHALL be ignored except err<=1, done pulse next cycle; no bus access.
REQ-012 start accepted only in IDLE; latch dev_addr, reg_addr, len; clear err; busy_o=1 from next cycle until the done cycle inclusive.
REQ-013 FSM states: IDLE, WR_PTR, WR_CMDW, WAIT_HI_W, WR_CMDR, WAIT_LO_W, WAIT_HI_R, WR_STOP, WAIT_LO_R, RD_DATA, ABORT, FINISH.
REQ-014 WR_PTR: write DATA=reg_addr. WR_CMDW: write ADDR-RW={0,dev_addr}.
REQ-015 WAIT_x states: repeatedly read UCR until busy bit matches target (HI=1, LO=0).
REQ-016 WAIT_HI_W -> WR_CMDR: write ADDR-RW={1,dev_addr} -> WAIT_LO_W -> WAIT_HI_R.
REQ-017 WAIT_HI_R: when byte index i==len-1 go WR_STOP (write UCR=0x00, clears ena) else go WAIT_LO_R directly.
REQ-018 WAIT_LO_R -> RD_DATA: read DATA, store bits 7:0 in buffer[i], i<=i+1; if i+1==len go FINISH else WAIT_HI_R.
REQ-019 Any UCR read with ack_error=1 SHALL go ABORT: write UCR=0x00, err<=1, then FINISH; buffer entries not yet read keep old values.
REQ-020 FINISH: done=1 one cycle, return to IDLE.
REQ-021 start while not IDLE SHALL be ignored; start in same cycle as FINISH ignored.
REQ-022 Buffer 8x8 bits, not cleared by reset or start; index 3 bits, no wrap beyond len.

Reset
REQ-023 reset SHALL force IDLE, abandon any bus cycle (cyc=stb=we=0 same edge), i=0.
REQ-024 Reset values: busy_o=0, done=0, err=0, wbm_adr_o=0, wbm_dat_o=0, wbm_sel_o=4'hF.
REQ-025 Reset mid-sequence SHALL NOT issue the UCR clear; I2C block recovery is its own reset.

Configuration
REQ-026 Macro I2C_SEQ_TIMEOUT_EN selects the poll watchdog.
REQ-027 Defined: 16-bit counter counts UCR polls within one WAIT state, cleared on state entry; reaching POLL_LIMIT goes ABORT (err=1). Undefined: no counter, waits are unbounded.

Structure
REQ-028 Shared package: register offsets (0x00/0x04/0x08), UCR bit positions, FSM state encoding.
REQ-029 One sub-module natural: wb_mst_port (single-access Wishbone master handshake, req/we/adr/dat in, done/rdata out).

Verification
REQ-030 Bench: wb_i2c_seq connected to a Wishbone slave model emulating the register map with scripted busy/ack_error.
REQ-031 dev=0x68, reg=0x3B, len=6, model returns 0x10..0x15 -> writes DATA=0x3B, ADDR=0x68, ADDR=0xE8; buffer[0..5]=0x10..0x15; one UCR=0 write; done once; err=0.
REQ-032 len=1, data 0xA5 -> UCR=0 write occurs before DATA read; buffer[0]=0xA5.
REQ-033 ack_error set on first poll -> UCR=0 written, err=1, done pulse, no DATA read.
REQ-034 start with len=0 -> no bus activity, err=1, done next cycle.
REQ-035 reset asserted mid-WAIT_LO_R with wbm_ack_i delayed -> cyc/stb low next cycle, busy_o=0; new start then completes normally.
REQ-036 With I2C_SEQ_TIMEOUT_EN, POLL_LIMIT=8, busy stuck 0 -> ABORT after 8 polls, err=1.
